// File: rtl/spi_pkg.sv
// Shared frame geometry, register map and controller state encoding for the
// SPI register-write initiator.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int RW_BIT  = 15;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  // Peripheral register map reachable through the frame address field
  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period tick generator: pulses tick_o once every HALF_PERIOD enabled
// cycles; clr_i restarts the count so the first tick lands HALF_PERIOD
// cycles after the clear.
module spi_sclk_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise wrap on the tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit {rw, addr[6:0], data[7:0]} frames, MSB
// first, with CIPO capture for read-back.
//
// User handshake: start is sampled only while busy=0; the cycle after
// acceptance busy=1 and the frame fields are frozen in the shift register.
// done is a one-cycle pulse in the cycle busy returns to 0; a start asserted
// in that same cycle is accepted, starts while busy=1 are dropped.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo,
  output logic [2:0]        state
);

  localparam int BW = $clog2(FRAME_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  spi_state_e        state_q, state_d;
  logic [RW_BIT-1:0] sreg_q, sreg_d;   // bits still to send after copi
  logic [DATA_W-1:0] cap_q, cap_d;     // last DATA_W bits seen on cipo
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              rw_q, rw_d;
  logic              sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept, tick;
  logic [FRAME_W-1:0] frame;

  assign frame = {rw, addr, wdata};

  spi_sclk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (busy_q),
    .tick_o (tick)
  );

  // Frame sequencing: next state and all bus/handshake outputs
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cap_d     = cap_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rw_d      = rw_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ncs_d     = ncs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          sreg_d    = frame[RW_BIT-1:0];
          copi_d    = frame[RW_BIT];
          rw_d      = rw;
          ncs_d     = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d    = 1'b1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          cap_d     = {cap_q[DATA_W-2:0], cipo};
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            cap_d     = {cap_q[DATA_W-2:0], cipo};
          end else begin
            sclk_d = 1'b0;
            // No shift after the last rising edge; copi keeps bit 0 into HOLD
            if (bit_cnt_q == BW'(FRAME_W)) begin
              state_d = ST_HOLD;
            end else begin
              copi_d = sreg_q[RW_BIT-1];
              sreg_d = {sreg_q[RW_BIT-2:0], 1'b0};
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // ncs stays high for CS_GAP whole half periods, done closes the next one
        if (tick) begin
          if (gap_cnt_q == GW'(CS_GAP)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (!rw_q) rdata_d = cap_q;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      cap_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rw_q      <= 1'b0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cap_q     <= cap_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rw_q      <= rw_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign copi  = copi_q;
  assign ncs   = ncs_q;
  assign state = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Testbench for spi_controller: a bus-side peripheral model decodes frames
// from sclk/copi/ncs into a register array and serves read data on cipo.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int HP   = 4;
  localparam int CG   = 2;
  localparam int HP2  = 2;
  localparam int CG2  = 1;
  localparam int LAT  = (34 + CG) * HP;
  localparam int LAT2 = (34 + CG2) * HP2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic       start = 1'b0, rw = 1'b0, cipo = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk, copi, ncs;
  logic [7:0] rdata;
  logic [2:0] state;

  // fast-parameter DUT
  logic       start2 = 1'b0, rw2 = 1'b0, cipo2 = 1'b0;
  logic [6:0] addr2 = '0;
  logic [7:0] wdata2 = '0;
  logic       busy2, done2, sclk2, copi2, ncs2;
  logic [7:0] rdata2;
  logic [2:0] state2;

  spi_controller #(.HALF_PERIOD(HP), .CS_GAP(CG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .state(state)
  );

  spi_controller #(.HALF_PERIOD(HP2), .CS_GAP(CG2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2), .copi(copi2), .ncs(ncs2),
    .cipo(cipo2), .state(state2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- peripheral reference model ----------------
  logic [7:0]  model_regs [0:127];
  logic [7:0]  rd_value = 8'h00;
  logic [7:0]  exp_rdata = 8'h00;
  logic [15:0] last_frame = '0;
  logic [15:0] shift_in = '0;
  logic [15:0] serve = '0;
  int          nbits = 0, frames_seen = 0, rises_seen = 0, bad_edges = 0;
  int          ncs_high_run = 0, last_ncs_gap = 0;
  logic        prev_sclk = 1'b0, prev_ncs = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; prev_sclk = 1'b0; prev_ncs = 1'b1; cipo = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        rises_seen++;
        if (ncs) bad_edges++;
        else begin shift_in = {shift_in[14:0], copi}; nbits++; end
      end
      if (!sclk && prev_sclk && ncs) bad_edges++;
      if (ncs) ncs_high_run++;
      else begin
        if (prev_ncs) last_ncs_gap = ncs_high_run;
        ncs_high_run = 0;
      end
      if (ncs && !prev_ncs) begin
        if (nbits == 16) begin
          frames_seen++;
          last_frame = shift_in;
          if (shift_in[15]) model_regs[shift_in[14:8]] = shift_in[7:0];
        end
        nbits = 0;
      end
      prev_sclk = sclk;
      prev_ncs  = ncs;
      // read data occupies the last 8 bit slots, MSB first
      serve = {8'h00, rd_value};
      if (!ncs && nbits < 16) cipo = serve[15 - nbits];
      else cipo = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_start(input logic r, input logic [6:0] a, input logic [7:0] d);
    rw = r; addr = a; wdata = d; start = 1'b1;
  endtask

  // Waits for done after the acceptance edge; scrambles frame inputs, pulses
  // start at cycle offsets pa/pb, or asserts reset once rst_rise rises seen.
  task automatic wait_frame(input int pa, input int pb, input int rst_rise,
                            output int lat, output logic [7:0] rd_at_done,
                            output logic busy_at_done, output bit got_done);
    int   rises;
    logic ps;
    rises = 0; got_done = 1'b0; lat = 0; rd_at_done = 'x; busy_at_done = 'x;
    @(posedge clk); #1;
    start = 1'b0;
    ps = sclk;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      rw    = 1'($urandom_range(0, 1));
      addr  = 7'($urandom_range(0, 127));
      wdata = 8'($urandom_range(0, 255));
      start = (n == pa || n == pb);
      if (sclk && !ps) rises++;
      ps = sclk;
      if (rst_rise != 0 && rises == rst_rise) begin
        #2 rst_n = 1'b0;
        break;
      end
      if (done) begin
        lat = n; rd_at_done = rdata; busy_at_done = busy; got_done = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else n_pass++;
    n_checks++; if (copi !== 1'b0) $display("FAIL reset_copi: got %b want 0", copi); else n_pass++;
    n_checks++; if (ncs !== 1'b1) $display("FAIL reset_ncs: got %b want 1", ncs); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); else n_pass++;
    n_checks++; if (ncs2 !== 1'b1) $display("FAIL reset_ncs2: got %b want 1", ncs2); else n_pass++;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ncs !== 1'b1) $display("FAIL idle_after_reset: got busy=%b ncs=%b want 0/1", busy, ncs); else n_pass++;
  endtask

  task automatic test_write_default();
    int lat, r0, f0; logic [7:0] rdd; logic bd; bit ok;
    logic [15:0] exp_f;
    r0 = rises_seen; f0 = frames_seen;
    exp_f = 16'b1000_0000_1010_0101;
    @(negedge clk); send_start(1'b1, REG_EN_OUT_7_0, 8'hA5);
    wait_frame(0, 0, 0, lat, rdd, bd, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL wr_done_seen: got %b want 1", ok); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL wr_latency: got %0d want %0d", lat, LAT); else n_pass++;
    n_checks++; if (last_frame !== exp_f) $display("FAIL wr_frame_bits: got %b want %b", last_frame, exp_f); else n_pass++;
    n_checks++; if (model_regs[0] !== 8'hA5) $display("FAIL wr_reg0: got %h want a5", model_regs[0]); else n_pass++;
    n_checks++; if (rdd !== exp_rdata) $display("FAIL wr_rdata_kept: got %h want %h", rdd, exp_rdata); else n_pass++;
    n_checks++; if (rises_seen - r0 != 16) $display("FAIL wr_rises: got %0d want 16", rises_seen - r0); else n_pass++;
    n_checks++; if (frames_seen - f0 != 1) $display("FAIL wr_frames: got %0d want 1", frames_seen - f0); else n_pass++;
  endtask

  task automatic test_read();
    int lat; logic [7:0] rdd, d; logic bd; bit ok;
    d = 8'($urandom_range(0, 255));
    rd_value = 8'h3C;
    @(negedge clk); send_start(1'b0, REG_PWM_DUTY, d);
    wait_frame(0, 0, 0, lat, rdd, bd, ok);
    exp_rdata = 8'h3C;
    n_checks++; if (ok !== 1'b1) $display("FAIL rd_done_seen: got %b want 1", ok); else n_pass++;
    n_checks++; if (rdd !== exp_rdata) $display("FAIL rd_rdata_at_done: got %h want %h", rdd, exp_rdata); else n_pass++;
    n_checks++; if (bd !== 1'b0) $display("FAIL rd_busy_at_done: got %b want 0", bd); else n_pass++;
    n_checks++; if (last_frame !== {1'b0, REG_PWM_DUTY, d}) $display("FAIL rd_frame_bits: got %h want %h", last_frame, {1'b0, REG_PWM_DUTY, d}); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (rdata !== exp_rdata) $display("FAIL rd_rdata_held: got %h want %h", rdata, exp_rdata); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat, r0, f0; logic [7:0] rdd, d; logic bd; bit ok;
    d = 8'($urandom_range(0, 254));
    r0 = rises_seen; f0 = frames_seen;
    @(negedge clk); send_start(1'b1, REG_EN_PWM_7_0, d);
    wait_frame(10, 60, 0, lat, rdd, bd, ok);
    repeat (200) @(negedge clk);
    n_checks++; if (ok !== 1'b1) $display("FAIL ign_done_seen: got %b want 1", ok); else n_pass++;
    n_checks++; if (frames_seen - f0 != 1) $display("FAIL ign_frames: got %0d want 1", frames_seen - f0); else n_pass++;
    n_checks++; if (rises_seen - r0 != 16) $display("FAIL ign_rises: got %0d want 16", rises_seen - r0); else n_pass++;
    n_checks++; if (model_regs[2] !== d) $display("FAIL ign_reg2: got %h want %h", model_regs[2], d); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_not_queued: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, f0; logic [7:0] rdd; logic bd; bit ok1, ok2;
    f0 = frames_seen;
    @(negedge clk); send_start(1'b1, REG_EN_PWM_7_0, 8'hFF);
    wait_frame(0, 0, 0, lat1, rdd, bd, ok1);
    send_start(1'b1, REG_PWM_DUTY, 8'h80);   // in the done cycle
    wait_frame(0, 0, 0, lat2, rdd, bd, ok2);
    n_checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) $display("FAIL b2b_done_seen: got %b%b want 11", ok1, ok2); else n_pass++;
    n_checks++; if (frames_seen - f0 != 2) $display("FAIL b2b_frames: got %0d want 2", frames_seen - f0); else n_pass++;
    n_checks++; if (model_regs[2] !== 8'hFF) $display("FAIL b2b_reg2: got %h want ff", model_regs[2]); else n_pass++;
    n_checks++; if (model_regs[4] !== 8'h80) $display("FAIL b2b_reg4: got %h want 80", model_regs[4]); else n_pass++;
    n_checks++; if (last_ncs_gap < CG * HP) $display("FAIL b2b_ncs_gap: got %0d want >= %0d", last_ncs_gap, CG * HP); else n_pass++;
    n_checks++; if (lat2 != LAT) $display("FAIL b2b_latency: got %0d want %0d", lat2, LAT); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int lat, f0; logic [7:0] rdd, old1; logic bd; bit ok;
    f0 = frames_seen; old1 = model_regs[1];
    @(negedge clk); send_start(1'b1, REG_EN_OUT_15_8, 8'h55);
    wait_frame(0, 0, 7, lat, rdd, bd, ok);
    #1;
    exp_rdata = 8'h00;
    n_checks++; if (ok !== 1'b0) $display("FAIL rst_aborted: got done_seen=%b want 0", ok); else n_pass++;
    n_checks++; if (ncs !== 1'b1) $display("FAIL rst_async_ncs: got %b want 1", ncs); else n_pass++;
    n_checks++; if (sclk !== 1'b0) $display("FAIL rst_async_sclk: got %b want 0", sclk); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rdata !== exp_rdata) $display("FAIL rst_async_rdata: got %h want %h", rdata, exp_rdata); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL rst_async_state: got %0d want %0d", state, ST_IDLE); else n_pass++;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (frames_seen != f0 || model_regs[1] !== old1) $display("FAIL rst_partial_discarded: got frames=%0d reg1=%h want %0d/%h", frames_seen, model_regs[1], f0, old1); else n_pass++;
    @(negedge clk); send_start(1'b1, REG_EN_OUT_15_8, 8'h0F);
    wait_frame(0, 0, 0, lat, rdd, bd, ok);
    n_checks++; if (ok !== 1'b1 || lat != LAT) $display("FAIL rst_next_frame: got done=%b lat=%0d want 1/%0d", ok, lat, LAT); else n_pass++;
    n_checks++; if (model_regs[1] !== 8'h0F) $display("FAIL rst_reg1: got %h want 0f", model_regs[1]); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic [7:0] rdd, d; logic [6:0] a; logic r, bd; bit ok;
    for (int it = 0; it < 8; it++) begin
      r = 1'($urandom_range(0, 1));
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom_range(0, 255));
      rd_value = 8'($urandom_range(0, 255));
      @(negedge clk); send_start(r, a, d);
      wait_frame(0, 0, 0, lat, rdd, bd, ok);
      if (!r) exp_rdata = rd_value;
      n_checks++; if (ok !== 1'b1 || lat != LAT) $display("FAIL rnd%0d_latency: got done=%b lat=%0d want 1/%0d", it, ok, lat, LAT); else n_pass++;
      n_checks++; if (last_frame !== {r, a, d}) $display("FAIL rnd%0d_frame: got %h want %h", it, last_frame, {r, a, d}); else n_pass++;
      n_checks++; if (rdd !== exp_rdata) $display("FAIL rnd%0d_rdata: got %h want %h", it, rdd, exp_rdata); else n_pass++;
      if (r) begin
        n_checks++; if (model_regs[a] !== d) $display("FAIL rnd%0d_reg: got %h want %h", it, model_regs[a], d); else n_pass++;
      end
    end
  endtask

  task automatic test_param_sweep();
    int lat, nb; logic [15:0] bits, exp_f; logic [7:0] d; logic [6:0] a; logic r, ps; bit got;
    for (int k = 0; k < 2; k++) begin
      r = (k == 0);
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom_range(0, 255));
      exp_f = {r, a, d};
      cipo2 = (k == 1);
      @(negedge clk); rw2 = r; addr2 = a; wdata2 = d; start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      ps = sclk2; bits = '0; nb = 0; got = 1'b0; lat = 0;
      for (int n = 1; n <= 300; n++) begin
        @(posedge clk); #1;
        if (sclk2 && !ps) begin bits = {bits[14:0], copi2}; nb++; end
        ps = sclk2;
        if (done2) begin lat = n; got = 1'b1; break; end
      end
      n_checks++; if (got !== 1'b1 || lat != LAT2) $display("FAIL sweep%0d_latency: got done=%b lat=%0d want 1/%0d", k, got, lat, LAT2); else n_pass++;
      n_checks++; if (nb != 16) $display("FAIL sweep%0d_rises: got %0d want 16", k, nb); else n_pass++;
      n_checks++; if (bits !== exp_f) $display("FAIL sweep%0d_frame: got %h want %h", k, bits, exp_f); else n_pass++;
      if (k == 1) begin
        n_checks++; if (rdata2 !== 8'hFF) $display("FAIL sweep_rdata: got %h want ff", rdata2); else n_pass++;
      end
    end
    cipo2 = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;
    test_reset();
    test_write_default();
    test_read();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_param_sweep();
    n_checks++; if (bad_edges != 0) $display("FAIL sclk_while_ncs_high: got %0d want 0", bad_edges); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
